// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, default bus widths and error classification.
// Also used by the bridge bench, so keep the encodings stable.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_WPROT = 2'b10
  } apb_err_e;

  // Range errors win, so a protected write to an unimplemented byte reports as a range error.
  function automatic apb_err_e apb_classify(input logic out_of_range, input logic write,
                                            input logic wp);
    if (out_of_range) return ERR_RANGE;
    if (write && wp) return ERR_WPROT;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte-array storage for the APB memory slave: one write port, one combinational
// read port, whole array cleared by the asynchronous reset.
module apb_slave_regfile #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (int'(waddr) < DEPTH)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Unimplemented addresses read as zero rather than indexing past the array.
  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: two-state transfer FSM, wait-state counter and registered
// PREADY/PRDATA/PSLVERR responses in front of a byte register file.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int MEM_DEPTH   = 192,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              wp,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic              prot_err
);

  localparam int              CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             ZERO_WAIT = (WAIT_STATES == 0);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              wp_q, wp_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              prot_err_q, prot_err_d;

  logic              setup_phase;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              in_err;
  logic              lat_err;
  logic              mem_we;

  // A zero-wait response is built at the setup edge, before anything is latched,
  // so the read port and error check look at the live bus during setup.
  assign setup_phase = PSEL && !PENABLE;
  assign rd_addr     = setup_phase ? PADDR : addr_q;
  assign in_err      = (apb_classify(int'(PADDR) >= MEM_DEPTH, PWRITE, wp) != ERR_NONE);
  assign lat_err     = (apb_classify(int'(addr_q) >= MEM_DEPTH, write_q, wp_q) != ERR_NONE);

  apb_slave_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (MEM_DEPTH)
  ) u_regfile (
    .clk  (PCLK),
    .rst  (PRESET),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    wp_d       = wp_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    prot_err_d = 1'b0;
    mem_we     = 1'b0;

    if (setup_phase) begin
      // A setup seen mid-transfer is an abort plus a fresh setup.
      prot_err_d = (state_q == ACCESS);
      state_d    = ACCESS;
      cnt_d      = CNT_INIT;
      addr_d     = PADDR;
      wdata_d    = PWDATA;
      write_d    = PWRITE;
      wp_d       = wp;
      pready_d   = ZERO_WAIT;
      if (ZERO_WAIT) begin
        pslverr_d = in_err;
        prdata_d  = (!PWRITE && !in_err) ? rd_data : '0;
      end
    end else if (state_q == IDLE) begin
      prot_err_d = PSEL && PENABLE;
    end else if (!PSEL) begin
      prot_err_d = 1'b1;
      state_d    = IDLE;
      cnt_d      = '0;
    end else if (pready_q) begin
      mem_we  = write_q && !lat_err;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      if (cnt_q <= CNT_ONE) begin
        pready_d  = 1'b1;
        pslverr_d = lat_err;
        prdata_d  = (!write_q && !lat_err) ? rd_data : '0;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      wp_q       <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      wp_q       <= wp_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign PRDATA   = prdata_q;
  assign prot_err = prot_err_q;

endmodule
